// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: opcode encodings, controller
// states and the divider iteration-counter width.
package alu_pkg;

    localparam int ALU_WIDTH_DEFAULT = 8;

    typedef enum logic [3:0] {
        ALU_ADD = 4'b0000,
        ALU_SUB = 4'b0001,
        ALU_AND = 4'b0010,
        ALU_OR  = 4'b0011,
        ALU_NOR = 4'b0100,
        ALU_XOR = 4'b0101,
        ALU_DIV = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_LSL = 4'b1000,
        ALU_LSR = 4'b1001
    } alu_op_e;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_DIVIDE = 1'b1
    } state_e;

    // The counter must hold the value WIDTH itself, hence the extra bit.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/alu_divider.sv
// Unsigned restoring divider: one quotient bit per cycle, MSB first.
// done and quotient/remainder are the values being committed at this edge.
module alu_divider
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = cnt_width(WIDTH);

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;

    logic [WIDTH:0]   shifted;
    logic             fits;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] quot_step;

    always_comb begin
        shifted   = {rem_q, quot_q[WIDTH-1]};
        fits      = shifted >= {1'b0, divisor_q};
        // When the trial subtraction fits, the true difference is below the
        // divisor, so the low WIDTH bits are exact.
        rem_step  = fits ? (shifted[WIDTH-1:0] - divisor_q) : shifted[WIDTH-1:0];
        quot_step = {quot_q[WIDTH-2:0], fits};
    end

    always_comb begin
        rem_d     = rem_q;
        quot_d    = quot_q;
        divisor_d = divisor_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        if (load) begin
            rem_d     = '0;
            quot_d    = dividend;
            divisor_d = divisor;
            cnt_d     = CW'(WIDTH);
            busy_d    = 1'b1;
        end else if (busy_q) begin
            rem_d  = rem_step;
            quot_d = quot_step;
            cnt_d  = cnt_q - CW'(1);
            busy_d = (cnt_q != CW'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rem_q     <= '0;
            quot_q    <= '0;
            divisor_q <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
        end else begin
            rem_q     <= rem_d;
            quot_q    <= quot_d;
            divisor_q <= divisor_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
        end
    end

    assign busy      = busy_q;
    assign done      = busy_q && (cnt_q == CW'(1));
    assign quotient  = quot_step;
    assign remainder = rem_step;

endmodule

// File: rtl/multicycle_alu.sv
// Execute-stage ALU with registered result/flags; single-cycle ops plus an
// iterative divide that holds busy until its quotient is ready.
//   state    | meaning
//   S_IDLE   | accepts start; 1-cycle ops and divide-by-zero complete here
//   S_DIVIDE | divider iterating, start ignored, done on final iteration
module multicycle_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       alucontrol,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] remainder,
    output logic             zero,
    output logic             err,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] SHIFT_LIMIT = WIDTH'(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             zero_q, zero_d;
    logic             err_q, err_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] op_res;
    logic [WIDTH-1:0] op_rem;
    logic             op_err;
    logic             div_launch;

    logic             div_load;
    logic             div_busy;
    logic             div_done;
    logic [WIDTH-1:0] div_quot;
    logic [WIDTH-1:0] div_rem;

    alu_divider #(
        .WIDTH(WIDTH)
    ) u_divider (
        .clk      (clk),
        .reset    (reset),
        .load     (div_load),
        .dividend (a),
        .divisor  (b),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quot),
        .remainder(div_rem)
    );

    always_comb begin
        op_res     = '0;
        op_rem     = '0;
        op_err     = 1'b0;
        div_launch = 1'b0;
        case (alucontrol)
            ALU_ADD: op_res = a + b;
            ALU_SUB: op_res = a - b;
            ALU_AND: op_res = a & b;
            ALU_OR:  op_res = a | b;
            ALU_NOR: op_res = ~(a | b);
            ALU_XOR: op_res = a ^ b;
            ALU_SLT: op_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_LSL: op_res = (b >= SHIFT_LIMIT) ? '0 : (a << b);
            ALU_LSR: op_res = (b >= SHIFT_LIMIT) ? '0 : (a >> b);
            ALU_DIV: begin
                if (b == '0) begin
                    op_res = '1;
                    op_rem = a;
                    op_err = 1'b1;
                end else begin
                    div_launch = 1'b1;
                end
            end
            // Illegal or unknown codes take the error path.
            default: op_err = 1'b1;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        remainder_d = remainder_q;
        zero_d      = zero_q;
        err_d       = err_q;
        done_d      = 1'b0;
        div_load    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (div_launch) begin
                        div_load = 1'b1;
                        state_d  = S_DIVIDE;
                    end else begin
                        result_d    = op_res;
                        remainder_d = op_rem;
                        zero_d      = (op_res == '0);
                        err_d       = op_err;
                        done_d      = 1'b1;
                    end
                end
            end
            S_DIVIDE: begin
                if (div_done) begin
                    result_d    = div_quot;
                    remainder_d = div_rem;
                    zero_d      = (div_quot == '0);
                    err_d       = 1'b0;
                    done_d      = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            result_q    <= '0;
            remainder_q <= '0;
            zero_q      <= 1'b0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            remainder_q <= remainder_d;
            zero_q      <= zero_d;
            err_q       <= err_d;
            done_q      <= done_d;
        end
    end

    assign result    = result_q;
    assign remainder = remainder_q;
    assign zero      = zero_q;
    assign err       = err_q;
    assign done      = done_q;
    assign busy      = (state_q == S_DIVIDE) && div_busy;

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed bench for multicycle_alu at WIDTH=8 with hand-computed expectations.
module tb_multicycle_alu;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [3:0]   alucontrol;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] result;
    logic [W-1:0] remainder;
    logic         zero;
    logic         err;
    logic         busy;
    logic         done;

    int n_tests = 0;
    int n_fail  = 0;

    multicycle_alu #(
        .WIDTH(W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .alucontrol(alucontrol),
        .a         (a),
        .b         (b),
        .result    (result),
        .remainder (remainder),
        .zero      (zero),
        .err       (err),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         z;
        logic         e;
    } vec_t;

    localparam int NVEC = 20;
    vec_t vecs [NVEC] = '{
        '{4'b0000, 8'hF0, 8'h20, 8'h10, 1'b0, 1'b0},
        '{4'b0001, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0},
        '{4'b0001, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0},
        '{4'b0010, 8'hCC, 8'hAA, 8'h88, 1'b0, 1'b0},
        '{4'b0011, 8'hCC, 8'hAA, 8'hEE, 1'b0, 1'b0},
        '{4'b0100, 8'hCC, 8'hAA, 8'h11, 1'b0, 1'b0},
        '{4'b0101, 8'hCC, 8'hAA, 8'h66, 1'b0, 1'b0},
        '{4'b0111, 8'h80, 8'h01, 8'h01, 1'b0, 1'b0},
        '{4'b0111, 8'h01, 8'h80, 8'h00, 1'b1, 1'b0},
        '{4'b0111, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0},
        '{4'b1000, 8'h81, 8'h01, 8'h02, 1'b0, 1'b0},
        '{4'b1000, 8'h81, 8'h08, 8'h00, 1'b1, 1'b0},
        '{4'b1000, 8'h01, 8'h07, 8'h80, 1'b0, 1'b0},
        '{4'b1001, 8'h81, 8'h09, 8'h00, 1'b1, 1'b0},
        '{4'b1001, 8'h81, 8'h07, 8'h01, 1'b0, 1'b0},
        '{4'b1001, 8'hF0, 8'h04, 8'h0F, 1'b0, 1'b0},
        '{4'b1010, 8'h12, 8'h34, 8'h00, 1'b1, 1'b1},
        '{4'b0000, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0},
        '{4'b1111, 8'h56, 8'h78, 8'h00, 1'b1, 1'b1},
        '{4'b0000, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0}
    };

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [W-1:0] va, input logic [W-1:0] vb);
        start      = 1'b1;
        alucontrol = op;
        a          = va;
        b          = vb;
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        alucontrol = 4'b0000;
        a          = '0;
        b          = '0;
        tick();
        tick();
        check("rst_result", 32'(result), 0);
        check("rst_rem",    32'(remainder), 0);
        check("rst_zero",   32'(zero), 0);
        check("rst_err",    32'(err), 0);
        check("rst_busy",   32'(busy), 0);
        check("rst_done",   32'(done), 0);
        reset = 1'b0;

        // Back-to-back single-cycle ops: one done per start.
        for (int i = 0; i < NVEC; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            tick();
            check($sformatf("vec%0d_done", i),   32'(done), 1);
            check($sformatf("vec%0d_result", i), 32'(result), 32'(vecs[i].res));
            check($sformatf("vec%0d_zero", i),   32'(zero), 32'(vecs[i].z));
            check($sformatf("vec%0d_err", i),    32'(err), 32'(vecs[i].e));
            check($sformatf("vec%0d_rem", i),    32'(remainder), 0);
            check($sformatf("vec%0d_busy", i),   32'(busy), 0);
        end
        start = 1'b0;
        tick();
        check("idle_done",  32'(done), 0);
        check("hold_zero",  32'(zero), 1);

        // DIV 200/7 with an ignored start and operand change at cycle 4.
        issue(4'b0110, 8'd200, 8'd7);
        tick();
        start = 1'b0;
        check("div_c1_busy", 32'(busy), 1);
        check("div_c1_done", 32'(done), 0);
        for (int c = 2; c <= 8; c++) begin
            if (c == 4) issue(4'b0000, 8'd1, 8'd1);
            else start = 1'b0;
            tick();
            check($sformatf("div_c%0d_busy", c), 32'(busy), 1);
            check($sformatf("div_c%0d_done", c), 32'(done), 0);
            if (c == 4) begin
                a = 8'hFF;
                b = 8'h01;
            end
        end
        start = 1'b0;
        tick();
        check("div_c9_done",   32'(done), 1);
        check("div_c9_busy",   32'(busy), 0);
        check("div_c9_result", 32'(result), 28);
        check("div_c9_rem",    32'(remainder), 4);
        check("div_c9_err",    32'(err), 0);
        check("div_c9_zero",   32'(zero), 0);
        // Start in the DIV done cycle is accepted.
        issue(4'b0000, 8'd3, 8'd4);
        tick();
        start = 1'b0;
        check("after_div_done",   32'(done), 1);
        check("after_div_result", 32'(result), 7);
        check("after_div_rem",    32'(remainder), 0);
        tick();
        check("after_div_idle", 32'(done), 0);
        check("hold_result",    32'(result), 7);

        // Divide by zero completes in one cycle without busy.
        issue(4'b0110, 8'h33, 8'h00);
        tick();
        start = 1'b0;
        check("dz_done",   32'(done), 1);
        check("dz_result", 32'(result), 'hFF);
        check("dz_rem",    32'(remainder), 'h33);
        check("dz_err",    32'(err), 1);
        check("dz_busy",   32'(busy), 0);
        tick();
        check("dz_busy2", 32'(busy), 0);
        check("dz_done2", 32'(done), 0);
        check("dz_hold_rem", 32'(remainder), 'h33);

        // DIV 255/3 aborted by reset in cycle 4.
        issue(4'b0110, 8'd255, 8'd3);
        tick();
        start = 1'b0;
        check("ab_c1_busy", 32'(busy), 1);
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("ab_c5_busy",   32'(busy), 0);
        check("ab_c5_done",   32'(done), 0);
        check("ab_c5_result", 32'(result), 0);
        check("ab_c5_rem",    32'(remainder), 0);
        check("ab_c5_zero",   32'(zero), 0);
        check("ab_c5_err",    32'(err), 0);
        for (int c = 6; c <= 12; c++) begin
            tick();
            check($sformatf("ab_c%0d_done", c), 32'(done), 0);
            check($sformatf("ab_c%0d_busy", c), 32'(busy), 0);
        end
        issue(4'b0000, 8'd2, 8'd3);
        tick();
        start = 1'b0;
        check("ab_add_done",   32'(done), 1);
        check("ab_add_result", 32'(result), 5);
        check("ab_add_err",    32'(err), 0);

        // A second full divide with a zero quotient: 5/9 = 0 r 5.
        issue(4'b0110, 8'd5, 8'd9);
        tick();
        start = 1'b0;
        for (int c = 2; c <= 8; c++) tick();
        check("div2_c8_busy", 32'(busy), 1);
        tick();
        check("div2_done",   32'(done), 1);
        check("div2_result", 32'(result), 0);
        check("div2_rem",    32'(remainder), 5);
        check("div2_zero",   32'(zero), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_alu.md
Name: multicycle_alu

Overview:
Execute-stage ALU that consumes the 4-bit alucontrol code from the ALU decoder and the two register operands, and produces a registered result with zero and error flags. All operations except DIV finish one cycle after start. DIV is an iterative restoring divider that holds the pipeline through busy. The controller issues start and waits for done before writeback.

Parameters:
WIDTH, 8, datapath width in bits (minimum 2; a power of two).

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  begin operation; sampled only when busy=0
alucontrol  input  4  operation code from ALU decoder
a  input  WIDTH  operand A (dividend for DIV)
b  input  WIDTH  operand B (divisor / shift amount)
result  output  WIDTH  registered result (quotient for DIV)
remainder  output  WIDTH  registered DIV remainder; 0 for other ops
zero  output  1  result == 0, registered with result
err  output  1  illegal alucontrol or divide-by-zero
busy  output  1  DIV in progress; start ignored
done  output  1  one-cycle pulse: result/remainder/zero/err valid

Behaviour:
- Opcodes: 0000 ADD, 0001 SUB (a-b), 0010 AND, 0011 OR, 0100 NOR, 0101 XOR, 0110 DIV, 0111 SLT, 1000 LSL, 1001 LSR. Codes 1010-1111 are illegal.
- Arithmetic is modulo 2^WIDTH, with no carry or overflow output. SLT is a signed two's-complement compare; result is 1 if a<b, else 0. DIV is unsigned.
- LSL/LSR: shift amount is the full unsigned b. If b >= WIDTH, result is 0. Zero fill.
- Reset (synchronous): state=IDLE; result, remainder, zero, err, busy, done all 0; divider registers cleared.
- Reset mid-DIV aborts the operation. No done is produced, and outputs are 0 the cycle after reset.
- States: IDLE, DIVIDE.
- IDLE, start=1, non-DIV or illegal op: result, flags and done=1 are registered at the next edge (latency 1). State stays IDLE.
- IDLE, start=1, DIV with b=0: latency 1. result all ones, remainder=a, err=1, done=1. No DIVIDE state.
- IDLE, start=1, DIV with b!=0:
  - Operands are latched and state moves to DIVIDE with busy=1 and a count of WIDTH.
  - Each DIVIDE cycle resolves one quotient bit, MSB first.
  - After WIDTH iterations the state returns to IDLE with busy=0 and done=1.
  - Start at cycle 0 gives busy in cycles 1..WIDTH and done in cycle WIDTH+1.
- Illegal op: result 0, remainder 0, zero=1, err=1, done=1.
- err is 0 for every legal, non-divide-by-zero op.
- done is high for exactly one cycle per accepted start.
- result, remainder, zero and err hold their values until the next done or reset.
- Back-to-back: start may be high every cycle for 1-cycle ops, giving done every cycle. Start in the done cycle of a DIV is accepted.
- start while busy=1 is ignored, with no queuing. Operand changes during DIVIDE have no effect (operands are latched).
- The ALU never produces x: unknown or illegal codes map to the err path.

Decomposition:
- Package alu_pkg:
  - alucontrol encodings as a 4-bit enum (ALU_ADD..ALU_LSR) shared with the ALU decoder.
  - State enum (S_IDLE, S_DIVIDE).
  - Iteration-counter width constant, $clog2(WIDTH)+1.
- Sub-module alu_divider, an unsigned restoring divider:
  - Handshake: load, busy, done.
  - Outputs: quotient, remainder.
  - Top-level owns the opcode mux, flags and output registers.

Test Plan (WIDTH=8):
1. start, ADD, a=0xF0, b=0x20 -> cycle 1: done=1, result=0x10, zero=0, err=0. Then SUB 0x05-0x05 -> result=0x00, zero=1.
2. start, DIV, a=200, b=7 -> busy=1 in cycles 1-8. Cycle 9: done=1, result=28, remainder=4, err=0. A start pulse with ADD at cycle 4 is ignored (no extra done).
3. DIV a=0x33, b=0 -> cycle 1: done=1, result=0xFF, remainder=0x33, err=1, busy never set.
4. SLT a=0x80, b=0x01 -> result=1. LSL a=0x81, b=1 -> 0x02. LSR a=0x81, b=9 -> 0x00, zero=1.
5. Illegal alucontrol=1010 -> done=1, err=1, result=0. Then a legal ADD clears err to 0.
6. DIV a=255, b=3 started, reset=1 in cycle 4 -> cycle 5: busy=0, done=0, all outputs 0. No done appears in cycles 5-12. A new ADD start afterwards completes normally.
